// File: rtl/count_rollover_monitor_pkg.sv
// Shared definitions for the count rollover monitor.
//   COUNT_W : width of the monitored count (fixed at 4 for this release)
//   state_e : monitor FSM state encoding, also exported on the debug state port
package count_rollover_monitor_pkg;

  localparam int unsigned COUNT_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StTrack = 2'b01,
    StError = 2'b10
  } state_e;

endpackage

// File: rtl/count_rollover_monitor_sample_sync.sv
// Two-stage sampler for a count that may glitch between clock edges.
// A sample is flagged valid only when both stages agree, so a value must be
// stable across two consecutive edges before downstream logic can use it.
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high reset, clears both stages to 0
//   i_d      : raw input value
//   o_sample : second-stage value
//   o_valid  : high when both stages hold the same value
module count_rollover_monitor_sample_sync #(
  parameter int unsigned W = count_rollover_monitor_pkg::COUNT_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sample,
  output logic         o_valid
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Sampling runs every cycle so the pipeline is already primed on re-enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_sample = r_s2;
  assign o_valid  = (r_s1 == r_s2);

endmodule

// File: rtl/count_rollover_monitor.sv
// Monitors a 4-bit serial carry counter: debounces its value, tracks it,
// pulses and counts on every accepted 15->0 rollover, and raises a sticky
// error when an accepted value is not the successor of the tracked value.
// Ports:
//   i_clk          : clock, rising edge
//   i_reset        : synchronous active-high reset
//   i_count_in     : raw count, may glitch between edges
//   i_enable       : 1 = monitor active, 0 = freeze and resync
//   i_clear_error  : one-cycle request to clear the sticky error (ERROR state only)
//   o_stable_count : last accepted count value
//   o_wrap_pulse   : one-cycle pulse on an accepted rollover
//   o_wrap_count   : saturating rollover count since reset
//   o_seq_error    : sticky sequence error flag
//   o_state        : FSM state for debug
module count_rollover_monitor #(
  parameter int unsigned WRAP_W  = 8,
  parameter int unsigned COUNT_W = count_rollover_monitor_pkg::COUNT_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [COUNT_W-1:0] i_count_in,
  input  logic               i_enable,
  input  logic               i_clear_error,
  output logic [COUNT_W-1:0] o_stable_count,
  output logic               o_wrap_pulse,
  output logic [WRAP_W-1:0]  o_wrap_count,
  output logic               o_seq_error,
  output logic [1:0]         o_state
);

  import count_rollover_monitor_pkg::*;

  state_e             r_state;
  state_e             w_state_next;
  logic [COUNT_W-1:0] r_stable_count;
  logic [WRAP_W-1:0]  r_wrap_count;
  logic               r_wrap_pulse;
  logic               r_seq_error;

  logic [COUNT_W-1:0] w_sample;
  logic               w_valid;
  logic               w_accept;
  logic [COUNT_W-1:0] w_succ;
  logic               w_same;
  logic               w_is_succ;
  logic               w_at_max;
  logic               w_bad;
  logic               w_load;
  logic               w_wrap;
  logic               w_set_err;
  logic               w_clr_err;

  count_rollover_monitor_sample_sync #(
    .W (COUNT_W)
  ) u_sample_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_d      (i_count_in),
    .o_sample (w_sample),
    .o_valid  (w_valid)
  );

  assign w_accept  = w_valid & i_enable;
  assign w_succ    = r_stable_count + {{(COUNT_W-1){1'b0}}, 1'b1};
  assign w_same    = (w_sample == r_stable_count);
  assign w_is_succ = (w_sample == w_succ);
  assign w_at_max  = &r_stable_count;
  // Only meaningful once a reference value exists (TRACK/ERROR).
  assign w_bad     = w_accept & ~w_same & ~w_is_succ;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    if (!i_enable) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (w_accept) w_state_next = StTrack;
        StTrack: if (w_bad) w_state_next = StError;
        StError: begin
          // A fresh sequence error beats a simultaneous clear request.
          if (w_bad) begin
            w_state_next = StError;
          end else if (i_clear_error) begin
            w_state_next = StTrack;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Output/action decode.
  always_comb begin
    w_load    = 1'b0;
    w_wrap    = 1'b0;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    case (r_state)
      StIdle: w_load = w_accept;
      StTrack, StError: begin
        w_load    = w_accept & ~w_same;
        w_wrap    = w_accept & w_is_succ & w_at_max;
        w_set_err = w_bad;
        w_clr_err = (r_state == StError) & i_enable & i_clear_error & ~w_bad;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stable_count <= '0;
      r_wrap_count   <= '0;
      r_wrap_pulse   <= 1'b0;
      r_seq_error    <= 1'b0;
    end else begin
      if (w_load) begin
        r_stable_count <= w_sample;
      end
      r_wrap_pulse <= w_wrap;
      if (w_wrap && !(&r_wrap_count)) begin
        r_wrap_count <= r_wrap_count + {{(WRAP_W-1){1'b0}}, 1'b1};
      end
      if (w_set_err) begin
        r_seq_error <= 1'b1;
      end else if (w_clr_err) begin
        r_seq_error <= 1'b0;
      end
    end
  end

  assign o_stable_count = r_stable_count;
  assign o_wrap_pulse   = r_wrap_pulse;
  assign o_wrap_count   = r_wrap_count;
  assign o_seq_error    = r_seq_error;
  assign o_state        = r_state;

endmodule

// File: tb/tb_count_rollover_monitor.sv
// Directed self-checking bench for count_rollover_monitor.
module tb_count_rollover_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       enable;
  logic       clear_error;
  logic [3:0] stable_count;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       seq_error;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  count_rollover_monitor #(
    .WRAP_W  (8),
    .COUNT_W (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_count_in     (count_in),
    .i_enable       (enable),
    .i_clear_error  (clear_error),
    .o_stable_count (stable_count),
    .o_wrap_pulse   (wrap_pulse),
    .o_wrap_count   (wrap_count),
    .o_seq_error    (seq_error),
    .o_state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; all sampling/driving happens 1ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (wrap_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] sc, input logic wp,
                           input logic [7:0] wc, input logic se, input logic [1:0] st);
    check({tag, ".stable"}, 32'(stable_count), 32'(sc));
    check({tag, ".pulse"}, 32'(wrap_pulse), 32'(wp));
    check({tag, ".wcount"}, 32'(wrap_count), 32'(wc));
    check({tag, ".err"}, 32'(seq_error), 32'(se));
    check({tag, ".state"}, 32'(state), 32'(st));
  endtask

  initial begin
    logic [3:0] v;
    reset       = 1'b1;
    enable      = 1'b0;
    count_in    = 4'd0;
    clear_error = 1'b0;
    tick(2);
    check_all("reset", 4'd0, 1'b0, 8'd0, 1'b0, 2'd0);

    // Count 0..15,0,1 with 4-cycle holds; value visible 3 edges after it appears.
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 18; i++) begin
      v        = 4'(i % 16);
      count_in = v;
      tick(3);
      check($sformatf("seq%0d.stable", i), 32'(stable_count), 32'(v));
      check($sformatf("seq%0d.pulse", i), 32'(wrap_pulse), (i == 16) ? 32'd1 : 32'd0);
      tick(1);
      check($sformatf("seq%0d.pulse_off", i), 32'(wrap_pulse), 32'd0);
    end
    check_all("seq_end", 4'd1, 1'b0, 8'd1, 1'b0, 2'd1);

    // Step up to 5, then a single-cycle glitch to 9 must be ignored.
    for (int i = 2; i <= 5; i++) begin
      count_in = 4'(i);
      tick(4);
    end
    check("hold5.stable", 32'(stable_count), 32'd5);
    count_in = 4'd9;
    tick(1);
    count_in = 4'd5;
    tick(2);
    check("glitch_mid.stable", 32'(stable_count), 32'd5);
    tick(3);
    check_all("glitch", 4'd5, 1'b0, 8'd1, 1'b0, 2'd1);

    // Resync to 3 across an enable gap: state IDLE while disabled, no error.
    enable   = 1'b0;
    count_in = 4'd3;
    tick(2);
    check_all("dis3", 4'd5, 1'b0, 8'd1, 1'b0, 2'd0);
    enable = 1'b1;
    tick(2);
    check_all("en3", 4'd3, 1'b0, 8'd1, 1'b0, 2'd1);

    // 3 -> 7 is not a successor.
    count_in = 4'd7;
    tick(3);
    check_all("err37", 4'd7, 1'b0, 8'd1, 1'b1, 2'd2);
    clear_error = 1'b1;
    tick(1);
    clear_error = 1'b0;
    check_all("clr_steady", 4'd7, 1'b0, 8'd1, 1'b0, 2'd1);

    // Back into ERROR (7->11->7), then clear coinciding with 7->2 acceptance.
    count_in = 4'd11;
    tick(3);
    check_all("err711", 4'd11, 1'b0, 8'd1, 1'b1, 2'd2);
    count_in = 4'd7;
    tick(3);
    check_all("err117", 4'd7, 1'b0, 8'd1, 1'b1, 2'd2);
    count_in = 4'd2;
    tick(2);
    clear_error = 1'b1;
    tick(1);
    clear_error = 1'b0;
    check_all("clr_vs_err", 4'd2, 1'b0, 8'd1, 1'b1, 2'd2);
    clear_error = 1'b1;
    tick(1);
    clear_error = 1'b0;
    check_all("clr2", 4'd2, 1'b0, 8'd1, 1'b0, 2'd1);
    clear_error = 1'b1;
    tick(1);
    clear_error = 1'b0;
    check_all("clr_track", 4'd2, 1'b0, 8'd1, 1'b0, 2'd1);

    // Resync to 12, then disable, move to 4, re-enable: no error, no wrap.
    enable   = 1'b0;
    count_in = 4'd12;
    tick(2);
    enable = 1'b1;
    tick(2);
    check_all("en12", 4'd12, 1'b0, 8'd1, 1'b0, 2'd1);
    enable = 1'b0;
    tick(1);
    count_in = 4'd4;
    tick(3);
    check_all("dis4", 4'd12, 1'b0, 8'd1, 1'b0, 2'd0);
    enable = 1'b1;
    tick(2);
    check_all("en4", 4'd4, 1'b0, 8'd1, 1'b0, 2'd1);

    // 257 rollovers with 2-cycle holds: saturates at 255, pulses every time.
    pulses = 0;
    for (int r = 0; r < 257; r++) begin
      for (int k = 1; k <= 16; k++) begin
        count_in = 4'((4 + k) % 16);
        tick(2);
      end
      if (r == 252) check("sat_m1.wcount", 32'(wrap_count), 32'd254);
      if (r == 253) check("sat.wcount", 32'(wrap_count), 32'd255);
    end
    tick(2);
    check("sat.pulses", 32'(pulses), 32'd257);
    check_all("sat_end", 4'd4, 1'b0, 8'hFF, 1'b0, 2'd1);

    // Error, then reset mid-stream with enable and clear_error active.
    count_in = 4'd9;
    tick(3);
    check_all("err49", 4'd9, 1'b0, 8'hFF, 1'b1, 2'd2);
    reset       = 1'b1;
    clear_error = 1'b1;
    tick(1);
    check_all("rst_mid", 4'd0, 1'b0, 8'd0, 1'b0, 2'd0);
    tick(1);
    check_all("rst_hold", 4'd0, 1'b0, 8'd0, 1'b0, 2'd0);
    reset       = 1'b0;
    clear_error = 1'b0;
    count_in    = 4'd0;
    tick(2);
    check_all("post_rst", 4'd0, 1'b0, 8'd0, 1'b0, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
